// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//
// Holds the PC and issues one word fetch at a time to instruction memory over
// a valid/ready request channel. Returned words are buffered, together with
// the PC they were fetched from, in a DEPTH-entry FIFO that feeds decode over
// a valid/ready handshake. A redirect flushes the FIFO, reloads the PC and
// discards any response still owed for a stale request.
//
// Optional build macro: FETCH_PERF_EN adds perf_fetched / perf_flushes counters.
//
// Ports:
//   clk, rst_n        core clock (rising edge), async active-low reset
//   imem_req_*        fetch request: valid/addr out, ready in
//   imem_resp_*       fetch response: valid/data in
//   redirect_valid/pc flush and restart fetch at redirect_pc (word aligned)
//   inst, inst_pc     FIFO head word and its PC (NOP / 0 when empty)
//   inst_valid/ready  decode handshake
//   perf_fetched      (FETCH_PERF_EN) responses pushed into the FIFO
//   perf_flushes      (FETCH_PERF_EN) cycles with redirect_valid asserted
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          req_valid_q, req_valid_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic accept;
  logic push;
  logic pop;

  assign accept = req_valid_q && imem_req_ready;
  assign push   = (state_q == S_WAIT) && imem_resp_valid && !redirect_valid;
  assign pop    = (count_q != '0) && inst_ready && !redirect_valid;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;

    case (state_q)
      S_REQ: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: if (imem_resp_valid) state_d = S_REQ;
      S_DROP: if (imem_resp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    // A redirect leaves any request still owed by memory pointing at a stale
    // PC; every such case shows up here as a pending S_WAIT, which becomes
    // S_DROP. A response arriving this same cycle has already moved to S_REQ.
    if (redirect_valid) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
      if (state_d == S_WAIT) state_d = S_DROP;
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Request valid is registered from next-state so it reads 0 during reset.
  assign req_valid_d = (state_d == S_REQ) && (count_d < FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Payload storage needs no reset: entries are only read when count_q says
  // they hold valid data.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= imem_resp_data;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (count_q != '0);
  assign inst           = inst_valid ? data_mem_q[rd_ptr_q] : NOP;
  assign inst_pc        = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (push)           perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect_valid) perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder with programmable
// latency, a reference model of the fetch state, and a scoreboard of the
// instructions expected at the FIFO head.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          LIMIT    = 200;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;
`endif

  fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  typedef enum {M_REQ, M_WAIT, M_DROP} mst_e;

  ent_t        sb[$];
  int          total = 0;
  int          fails = 0;
  mst_e        m_state;
  logic [31:0] exp_pc;
  logic [31:0] inflight_pc;
  bit          m_rstv;
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_a;
  int          lat;
  bit          acc_dut;
  logic [31:0] acc_addr;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_state  = M_REQ;
    exp_pc   = RESET_PC;
    m_rstv   = 1'b1;
    mem_busy = 1'b0;
    mem_cnt  = 0;
  endtask

  // One clock: entered at a negedge with inputs set by the caller; checks
  // outputs, advances the model to the coming posedge, returns at next negedge.
  task automatic cyc();
    logic m_acc, m_pop, rv, exp_rv;
    ent_t e;
    imem_resp_valid = mem_busy && (mem_cnt == 0);
    imem_resp_data  = imem_resp_valid ? memdata(mem_a) : 32'hDEAD_BEEF;
    #1;
    chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("inst", inst, sb[0].data);
      chk("inst_pc", inst_pc, sb[0].pc);
    end else begin
      chk("inst_empty", inst, NOP);
      chk("inst_pc_empty", inst_pc, 32'h0);
    end
    exp_rv = !m_rstv && (m_state == M_REQ) && (sb.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("req_addr", imem_req_addr, exp_pc);

    acc_dut  = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    m_acc    = exp_rv && imem_req_ready;
    m_pop    = (sb.size() != 0) && inst_ready;
    rv       = imem_resp_valid;

    if (redirect_valid) begin
      sb.delete();
      exp_pc = redirect_pc & ~32'd3;
      if (m_state == M_REQ) m_state = m_acc ? M_DROP : M_REQ;
      else                  m_state = rv ? M_REQ : M_DROP;
    end else begin
      if (m_pop) void'(sb.pop_front());
      case (m_state)
        M_REQ: if (m_acc) begin
          inflight_pc = exp_pc;
          exp_pc      = exp_pc + 32'd4;
          m_state     = M_WAIT;
        end
        M_WAIT: if (rv) begin
          e.pc   = inflight_pc;
          e.data = memdata(inflight_pc);
          sb.push_back(e);
          m_state = M_REQ;
        end
        default: if (rv) m_state = M_REQ;
      endcase
    end
    m_rstv = 1'b0;

    @(posedge clk);
    #1;
    if (imem_resp_valid) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (acc_dut) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
      mem_a    = acc_addr;
    end
    @(negedge clk);
  endtask

  initial begin
    int guard;
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    inst_ready      = 1'b0;
    lat             = 0;
    model_reset();

    // Reset values
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_inst_pc", inst_pc, 32'h0);
    @(negedge clk);

    // Streaming with 1-cycle response latency, decode always ready
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    repeat (10) cyc();

    // Decode stalled: FIFO fills, requests stop; one pop re-enables a request
    inst_ready = 1'b0;
    repeat (14) cyc();
    chk("full_count", 32'(sb.size()), DEPTH);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    repeat (4) cyc();

    // Redirect to 0x103 while waiting on a slow response
    inst_ready = 1'b1;
    lat        = 2;
    guard      = 0;
    while (!(m_state == M_WAIT && !(mem_busy && mem_cnt == 0)) && guard < LIMIT) begin
      cyc();
      guard++;
    end
    chk("wait_s_wait", 32'(guard < LIMIT), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    cyc();
    redirect_valid = 1'b0;
    repeat (12) cyc();

    // Redirect coinciding with a response and a pop
    lat        = 0;
    inst_ready = 1'b0;
    guard      = 0;
    while (!(m_state == M_WAIT && sb.size() >= 1 && mem_busy && mem_cnt == 0) && guard < LIMIT) begin
      cyc();
      guard++;
    end
    chk("wait_resp_pop", 32'(guard < LIMIT), 32'd1);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0020;
    cyc();
    redirect_valid = 1'b0;

    // Redirect coinciding with acceptance of the 0x20 request
    lat   = 1;
    guard = 0;
    while (!(m_state == M_REQ && sb.size() < DEPTH && !m_rstv && exp_pc == 32'h20) && guard < LIMIT) begin
      cyc();
      guard++;
    end
    chk("wait_acc_20", 32'(guard < LIMIT), 32'd1);
    chk("acc_20_addr", imem_req_addr, 32'h20);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0302;
    cyc();
    redirect_valid = 1'b0;
    repeat (10) cyc();

    // Asynchronous reset mid-S_WAIT with two entries buffered
    inst_ready = 1'b0;
    lat        = 3;
    guard      = 0;
    while (!(m_state == M_WAIT && sb.size() == 2) && guard < LIMIT) begin
      cyc();
      guard++;
    end
    chk("wait_two_buf", 32'(guard < LIMIT), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_inst_valid", 32'(inst_valid), 32'd0);
    chk("async_req_valid", 32'(imem_req_valid), 32'd0);
    chk("async_inst", inst, NOP);
    model_reset();
    imem_resp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    lat        = 0;
    repeat (8) cyc();

    // Mixed traffic: random stalls, latencies and occasional redirects
    for (int i = 0; i < 400; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      lat            = $urandom_range(0, 2);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      cyc();
    end
    redirect_valid = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
